dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single physical port of the dcache data SRAM between four requesters: DMA write (stage 3), DMA read (stage 1), CISA store (stage 2) and CISA load (stage 1).
- Issues at most one SRAM access per cycle and returns read data one cycle later, tagged to its owner.
- Honours the global freeze: CISA requesters are never granted while frozen. DMA is never frozen.
- Bounds CISA starvation with per-requester age counters.

Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 18, SRAM data width
- STARVE_LIMIT, 8, consecutive denied request cycles after which a CISA requester is promoted to top priority (legal range 1..255)

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low reset
- freeze  in  1  global pipeline freeze; blocks CISA grants
- dma_lock  in  1  while high, only DMA requesters may be granted (burst ownership)
- dwr_req  in  1  DMA write request
- dwr_addr  in  ADDR_W  DMA write address
- dwr_data  in  DATA_W  DMA write data
- dwr_gnt  out  1  DMA write granted this cycle
- drd_req  in  1  DMA read request
- drd_addr  in  ADDR_W  DMA read address
- drd_gnt  out  1  DMA read granted
- drd_rvalid  out  1  DMA read data valid on rdata
- st_req  in  1  CISA store request
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_gnt  out  1  store granted
- ld_req  in  1  CISA load request
- ld_addr  in  ADDR_W  load address
- ld_gnt  out  1  load granted
- ld_rvalid  out  1  load data valid on rdata
- rdata  out  DATA_W  registered read data (shared)
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en & !mem_we
- cisa_stall  out  1  a CISA request is pending and was not granted this cycle

Behaviour:
Reset (reset low, asynchronous):
- All gnt, rvalid, mem_en, mem_we, cisa_stall = 0; rdata = 0.
- Age counters = 0; owner register = NONE.

Handshake:
- Each requester holds req, addr and data stable until it sees gnt.
- The transfer occurs in the cycle where req & gnt are both high.
- Grants are combinational in the request cycle; exactly one gnt is high, or none.
- The mem_* signals are combinational from the winner.

Eligibility (per cycle):
- DMA requesters are always eligible.
- st and ld are eligible only when !freeze & !dma_lock.

Priority among eligible requesters:
1. A CISA requester whose age counter == STARVE_LIMIT. If both are promoted, st wins.
2. dwr
3. drd
4. st
5. ld

Age counters (8 bit, one each for st and ld):
- Increment, saturating at STARVE_LIMIT, on a cycle with req & !gnt & !freeze.
- Clear on grant, or on req low.
- Hold while freeze is high.

Read return:
- The owner register captures {DRD, LD, NONE} at grant.
- Next cycle: rdata <= mem_rdata and the matching rvalid = 1 for exactly one cycle.
- Write grants return nothing.
- Read return continues during freeze; return latency is fixed at 1 cycle.

Outputs and data rules:
- cisa_stall = (st_req & !st_gnt) | (ld_req & !ld_gnt).
- No address comparison or forwarding. Ordering between st and ld in the same cycle is by priority: the store lands before the load.

Boundary conditions:
- No request pending: mem_en = 0.
- All four requesting: dwr wins unless a CISA counter is saturated.
- freeze asserted mid-starvation: the counter holds its value; it is not reset.
- Reset mid-read: the pending rvalid is dropped.

Decomposition:
- Shared package: owner enum {OWN_NONE, OWN_DRD, OWN_LD}, requester index constants, default ADDR_W/DATA_W.
- One natural sub-module: starve_counter (saturating, hold on freeze, clear on grant), instantiated twice.

Test Plan:
- Reset with all req high → all gnt = 0, mem_en = 0. Release reset, no freeze → dwr_gnt = 1, mem_we = 1, mem_addr = dwr_addr.
- drd_req addr 0x00010, SRAM returns 0x2A → drd_gnt at cycle N; drd_rvalid = 1, rdata = 0x2A at N+1 only.
- freeze = 1 with ld_req = 1 for 5 cycles → ld_gnt = 0, cisa_stall = 1, ld age counter stays 0. freeze = 0 with no DMA requests → ld_gnt the next cycle.
- dwr_req held high, st_req high, STARVE_LIMIT = 8 → st denied 8 cycles, st_gnt on the 9th cycle, dwr resumes the following cycle.
- st_req and ld_req in the same cycle, addr 0x00005, st_data 0x3FFFF → st granted first (write); ld granted next cycle; ld_rvalid with rdata = 0x3FFFF.
- dma_lock = 1, ld_req and drd_req pending → only drd granted. After drd_req drops with lock still high → ld not granted; cisa_stall = 1.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and constants for the dcache data-SRAM port arbiter.
package dcache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DRD  = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    localparam int REQ_DWR = 0;
    localparam int REQ_DRD = 1;
    localparam int REQ_ST  = 2;
    localparam int REQ_LD  = 3;
    localparam int NUM_REQ = 4;

    // CISA requesters only, in promotion-priority order (st before ld)
    localparam int NUM_CISA = 2;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 18;
    localparam int AGE_W      = 8;

endpackage

// File: rtl/dcache_port_arbiter_starve_counter.sv
// Saturating per-requester age counter; flags a CISA requester that has waited
// LIMIT unfrozen cycles so the arbiter can lift it to top priority.
module dcache_port_arbiter_starve_counter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    input  logic req,
    input  logic gnt,
    output logic promoted
);

    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(LIMIT);

    logic [AGE_W-1:0] r_age;

    // Freeze outranks a dropped request so a frozen requester keeps its age.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_age <= '0;
        end else if (gnt) begin
            r_age <= '0;
        end else if (freeze) begin
            r_age <= r_age;
        end else if (!req) begin
            r_age <= '0;
        end else if (r_age != LIMIT_C) begin
            r_age <= r_age + AGE_W'(1);
        end
    end

    assign promoted = (r_age == LIMIT_C);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single-port dcache data SRAM arbiter: DMA write/read, CISA store/load,
// one access per cycle, read data returned one cycle later tagged to its owner.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              dma_lock,
    input  logic              dwr_req,
    input  logic [ADDR_W-1:0] dwr_addr,
    input  logic [DATA_W-1:0] dwr_data,
    output logic              dwr_gnt,
    input  logic              drd_req,
    input  logic [ADDR_W-1:0] drd_addr,
    output logic              drd_gnt,
    output logic              drd_rvalid,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_gnt,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cisa_stall
);

    logic [NUM_REQ-1:0]  w_gnt;
    logic [NUM_CISA-1:0] w_cisa_req;
    logic [NUM_CISA-1:0] w_cisa_gnt;
    logic [NUM_CISA-1:0] w_promoted;
    logic                w_cisa_ok;
    owner_e              w_owner_next;
    owner_e              r_owner;
    logic [DATA_W-1:0]   r_rdata;

    assign w_cisa_ok  = !freeze && !dma_lock;
    assign w_cisa_req = {ld_req, st_req};
    assign w_cisa_gnt = {w_gnt[REQ_LD], w_gnt[REQ_ST]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CISA; gi++) begin : g_age
            dcache_port_arbiter_starve_counter #(
                .LIMIT (STARVE_LIMIT)
            ) u_age (
                .clk      (clk),
                .reset    (reset),
                .freeze   (freeze),
                .req      (w_cisa_req[gi]),
                .gnt      (w_cisa_gnt[gi]),
                .promoted (w_promoted[gi])
            );
        end
    endgenerate

    always_comb begin
        w_gnt = '0;
        if (reset) begin
            if (w_cisa_ok && st_req && w_promoted[0]) begin
                w_gnt[REQ_ST] = 1'b1;
            end else if (w_cisa_ok && ld_req && w_promoted[1]) begin
                w_gnt[REQ_LD] = 1'b1;
            end else if (dwr_req) begin
                w_gnt[REQ_DWR] = 1'b1;
            end else if (drd_req) begin
                w_gnt[REQ_DRD] = 1'b1;
            end else if (w_cisa_ok && st_req) begin
                w_gnt[REQ_ST] = 1'b1;
            end else if (w_cisa_ok && ld_req) begin
                w_gnt[REQ_LD] = 1'b1;
            end
        end
    end

    assign dwr_gnt = w_gnt[REQ_DWR];
    assign drd_gnt = w_gnt[REQ_DRD];
    assign st_gnt  = w_gnt[REQ_ST];
    assign ld_gnt  = w_gnt[REQ_LD];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[REQ_DWR]) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dwr_addr;
            mem_wdata = dwr_data;
        end else if (w_gnt[REQ_DRD]) begin
            mem_en    = 1'b1;
            mem_addr  = drd_addr;
        end else if (w_gnt[REQ_ST]) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = st_addr;
            mem_wdata = st_data;
        end else if (w_gnt[REQ_LD]) begin
            mem_en    = 1'b1;
            mem_addr  = ld_addr;
        end
    end

    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_gnt[REQ_DRD]) begin
            w_owner_next = OWN_DRD;
        end else if (w_gnt[REQ_LD]) begin
            w_owner_next = OWN_LD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= OWN_NONE;
            r_rdata <= '0;
        end else begin
            r_owner <= w_owner_next;
            if (r_owner != OWN_NONE) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // The SRAM already registers its output, so the return cycle passes it
    // straight through; r_rdata keeps the last return visible afterwards.
    assign rdata      = (r_owner != OWN_NONE) ? mem_rdata : r_rdata;
    assign drd_rvalid = (r_owner == OWN_DRD);
    assign ld_rvalid  = (r_owner == OWN_LD);

    assign cisa_stall = reset && ((st_req && !w_gnt[REQ_ST]) || (ld_req && !w_gnt[REQ_LD]));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a read-return scoreboard and a
// registered-read SRAM model on the memory port.
module tb_dcache_port_arbiter;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_DRD  = 2'd1;
    localparam logic [1:0] O_LD   = 2'd2;

    typedef struct packed {
        logic [1:0]  own;
        logic [17:0] data;
    } ret_t;

    logic        clk;
    logic        reset;
    logic        freeze, dma_lock;
    logic        dwr_req, drd_req, st_req, ld_req;
    logic [17:0] dwr_addr, drd_addr, st_addr, ld_addr;
    logic [17:0] dwr_data, st_data;
    logic        dwr_gnt, drd_gnt, st_gnt, ld_gnt;
    logic        drd_rvalid, ld_rvalid;
    logic [17:0] rdata;
    logic        mem_en, mem_we;
    logic [17:0] mem_addr, mem_wdata, mem_rdata;
    logic        cisa_stall;

    logic [17:0] sram [0:255];
    ret_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    dcache_port_arbiter #(
        .ADDR_W       (18),
        .DATA_W       (18),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .freeze     (freeze),
        .dma_lock   (dma_lock),
        .dwr_req    (dwr_req),
        .dwr_addr   (dwr_addr),
        .dwr_data   (dwr_data),
        .dwr_gnt    (dwr_gnt),
        .drd_req    (drd_req),
        .drd_addr   (drd_addr),
        .drd_gnt    (drd_gnt),
        .drd_rvalid (drd_rvalid),
        .st_req     (st_req),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_gnt     (st_gnt),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cisa_stall (cisa_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: preloaded while in reset, read data valid the cycle after the access
    always @(posedge clk) begin
        if (!reset) begin
            sram[8'h10] <= 18'h0002A;
            sram[8'h20] <= 18'h00155;
            mem_rdata   <= 18'h0;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[7:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: check grants now, queue the expected return,
    // then step to the next cycle and compare what the DUT returned.
    task automatic cyc(input string tag, input logic [3:0] g, input logic stall,
                       input logic we, input logic [17:0] addr,
                       input logic [1:0] own, input logic [17:0] rd);
        ret_t e;
        logic [1:0] rv_exp;
        #1;
        chk({tag, ":gnt"}, {28'b0, dwr_gnt, drd_gnt, st_gnt, ld_gnt}, {28'b0, g});
        chk({tag, ":stall"}, {31'b0, cisa_stall}, {31'b0, stall});
        chk({tag, ":mem_en"}, {31'b0, mem_en}, {31'b0, |g});
        if (g != 4'b0) begin
            chk({tag, ":mem_we"}, {31'b0, mem_we}, {31'b0, we});
            chk({tag, ":mem_addr"}, {14'b0, mem_addr}, {14'b0, addr});
        end
        e.own  = own;
        e.data = rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        rv_exp = (e.own == O_DRD) ? 2'b10 : (e.own == O_LD) ? 2'b01 : 2'b00;
        chk({tag, ":rvalid"}, {30'b0, drd_rvalid, ld_rvalid}, {30'b0, rv_exp});
        if (e.own != O_NONE) begin
            chk({tag, ":rdata"}, {14'b0, rdata}, {14'b0, e.data});
        end
        $display("cycle %s gnt=%b%b%b%b stall=%b rvalid=%b%b rdata=0x%0h",
                 tag, dwr_gnt, drd_gnt, st_gnt, ld_gnt, cisa_stall, drd_rvalid, ld_rvalid, rdata);
    endtask

    initial begin
        reset = 1'b0; freeze = 1'b0; dma_lock = 1'b0;
        dwr_req = 1'b1; dwr_addr = 18'h3;  dwr_data = 18'h7;
        drd_req = 1'b1; drd_addr = 18'h10;
        st_req  = 1'b1; st_addr  = 18'h31; st_data  = 18'h222;
        ld_req  = 1'b1; ld_addr  = 18'h20;

        // Reset with every requester asserted: nothing may be granted
        cyc("rst0", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);
        cyc("rst1", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);
        chk("rst:rdata", {14'b0, rdata}, 32'h0);

        reset = 1'b1;
        #1;
        chk("all_req:wdata", {14'b0, mem_wdata}, 32'h7);
        cyc("all_req", 4'b1000, 1'b1, 1'b1, 18'h3, O_NONE, 18'h0);
        dwr_req = 1'b0; drd_req = 1'b0; st_req = 1'b0; ld_req = 1'b0;
        cyc("idle0", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // DMA read, data returned exactly one cycle later
        drd_req = 1'b1; drd_addr = 18'h10;
        cyc("drd", 4'b0100, 1'b0, 1'b0, 18'h10, O_DRD, 18'h2A);
        drd_req = 1'b0;
        cyc("drd_after", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // Frozen load is never granted, granted as soon as freeze lifts
        freeze = 1'b1; ld_req = 1'b1; ld_addr = 18'h20;
        for (int i = 0; i < 5; i++) cyc("frz_ld", 4'b0000, 1'b1, 1'b0, 18'h0, O_NONE, 18'h0);
        freeze = 1'b0;
        cyc("unfrz_ld", 4'b0001, 1'b0, 1'b0, 18'h20, O_LD, 18'h155);
        ld_req = 1'b0;
        cyc("idle1", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // Store starved by continuous DMA writes is promoted after 8 denials
        dwr_req = 1'b1; dwr_addr = 18'h30; dwr_data = 18'h111;
        st_req  = 1'b1; st_addr  = 18'h31; st_data  = 18'h222;
        for (int i = 0; i < 8; i++) cyc("starve_dwr", 4'b1000, 1'b1, 1'b1, 18'h30, O_NONE, 18'h0);
        cyc("starve_st", 4'b0010, 1'b0, 1'b1, 18'h31, O_NONE, 18'h0);
        st_req = 1'b0;
        cyc("dwr_resume", 4'b1000, 1'b0, 1'b1, 18'h30, O_NONE, 18'h0);
        dwr_req = 1'b0;

        // Same-cycle store and load: store lands first, load reads it back
        st_req = 1'b1; st_addr = 18'h5; st_data = 18'h3FFFF;
        ld_req = 1'b1; ld_addr = 18'h5;
        #1;
        chk("stld:wdata", {14'b0, mem_wdata}, 32'h3FFFF);
        cyc("stld_st", 4'b0010, 1'b1, 1'b1, 18'h5, O_NONE, 18'h0);
        st_req = 1'b0;
        cyc("stld_ld", 4'b0001, 1'b0, 1'b0, 18'h5, O_LD, 18'h3FFFF);
        ld_req = 1'b0;
        cyc("idle2", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // DMA lock: only DMA is served, CISA stalls even with the port idle
        dma_lock = 1'b1; ld_req = 1'b1; ld_addr = 18'h20; drd_req = 1'b1; drd_addr = 18'h10;
        cyc("lock_drd", 4'b0100, 1'b1, 1'b0, 18'h10, O_DRD, 18'h2A);
        drd_req = 1'b0;
        cyc("lock_idle0", 4'b0000, 1'b1, 1'b0, 18'h0, O_NONE, 18'h0);
        cyc("lock_idle1", 4'b0000, 1'b1, 1'b0, 18'h0, O_NONE, 18'h0);
        dma_lock = 1'b0;
        cyc("unlock_ld", 4'b0001, 1'b0, 1'b0, 18'h20, O_LD, 18'h155);
        ld_req = 1'b0;
        cyc("idle3", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // Freeze mid-starvation: load age holds at 4 across the freeze
        dwr_req = 1'b1; dwr_addr = 18'h40; dwr_data = 18'h99;
        ld_req  = 1'b1; ld_addr  = 18'h20;
        for (int i = 0; i < 4; i++) cyc("age_pre", 4'b1000, 1'b1, 1'b1, 18'h40, O_NONE, 18'h0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) cyc("age_frz", 4'b1000, 1'b1, 1'b1, 18'h40, O_NONE, 18'h0);
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) cyc("age_post", 4'b1000, 1'b1, 1'b1, 18'h40, O_NONE, 18'h0);
        cyc("age_ld", 4'b0001, 1'b0, 1'b0, 18'h20, O_LD, 18'h155);
        ld_req = 1'b0;
        cyc("age_dwr", 4'b1000, 1'b0, 1'b1, 18'h40, O_NONE, 18'h0);
        dwr_req = 1'b0;
        cyc("idle4", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        // Reset arriving while a read return is pending drops the return
        drd_req = 1'b1; drd_addr = 18'h10;
        #1;
        chk("rmr:gnt", {31'b0, drd_gnt}, 32'h1);
        @(posedge clk);
        reset = 1'b0; drd_req = 1'b0;
        #1;
        chk("rmr:rvalid", {31'b0, drd_rvalid}, 32'h0);
        chk("rmr:rdata", {14'b0, rdata}, 32'h0);
        chk("rmr:mem_en", {31'b0, mem_en}, 32'h0);
        $display("cycle rmr rvalid=%b%b rdata=0x%0h", drd_rvalid, ld_rvalid, rdata);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("post_rst", 4'b0000, 1'b0, 1'b0, 18'h0, O_NONE, 18'h0);

        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
